neuron_accumulator: RTL and testbench
=====================================

Name: neuron_accumulator

Overview:
Downstream stage of signed_fixed_point_multiplier. Consumes its stream of saturated Q5.10 products for one neuron and sums them in a guarded accumulator. At end of vector it adds the neuron bias, saturates to 16 bits, applies optional ReLU, and presents the activation on a valid/ready output. This is the "sum + bias + activation" half of a neuron; the multiplier is the "weight x input" half.

Parameters:
FIXED_POINT_LENGTH, 16, total bits of the signed fixed-point word.
FIXED_POINT_POSITION, 10, fractional bits (Q5.10); no rescaling is done here because addition is scale-preserving.
ACCUM_GUARD_BITS, 8, extra integer bits in the accumulator; ACC_W = FIXED_POINT_LENGTH + ACCUM_GUARD_BITS.
RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass signed result.

Ports:
clk_in  input  1  system clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
product_in  input  FIXED_POINT_LENGTH  signed Q5.10 product from multiplier
product_valid_in  input  1  product_in valid this cycle
product_last_in  input  1  qualifies final product of the vector
product_ready_out  output  1  accumulator accepts a product this cycle
bias_in  input  FIXED_POINT_LENGTH  signed Q5.10 bias, sampled with the last beat
neuron_out  output  FIXED_POINT_LENGTH  signed Q5.10 activation
neuron_valid_out  output  1  neuron_out valid; held until accepted
neuron_ready_in  input  1  downstream accepts neuron_out
busy_out  output  1  high from first accepted beat until output handshake

Behaviour:
- Reset (async, rst_n_in=0): state=ACCUM, acc=0, bias reg=0, neuron_out=0, neuron_valid_out=0, busy_out=0. A reset mid-vector discards partial sums; no output is produced for that vector.
- Beat accepted when product_valid_in && product_ready_out. product_ready_out = (state==ACCUM), combinational from state only.
- States:
  - ACCUM: each accepted beat computes acc <= sat_acc(acc + sext(product_in)). If product_last_in is set, also bias_reg <= bias_in and go to FINISH.
  - FINISH (exactly 1 cycle): s = acc + sext(bias_in reg). Clamp s to [-2^(L-1), 2^(L-1)-1]. If RELU_EN and s<0, use 0. Register the result to neuron_out, set neuron_valid_out=1, go to OUTPUT.
  - OUTPUT: neuron_out/neuron_valid_out held stable. On neuron_ready_in=1, clear valid and acc, drop busy_out, go to ACCUM.
- Latency: last beat accepted at edge N; neuron_valid_out=1 after edge N+1. Minimum vector-to-vector throughput is L+2 cycles for a vector of L beats.
- The accumulator saturates at its own bounds, [-2^(ACC_W-1), 2^(ACC_W-1)-1], on every add. It does not wrap.
- A single-beat vector (valid and last on the first beat) is legal.
- product_last_in is ignored when product_valid_in=0.
- In FINISH/OUTPUT no beats are accepted. An upstream product held valid stalls without loss.
- neuron_ready_in asserted outside OUTPUT has no effect.
- busy_out goes high on the first accepted beat, including a single-beat vector.

Decomposition:
- Package nn_fixed_point_pkg holds:
  - FIXED_POINT_LENGTH and FIXED_POINT_POSITION defaults.
  - typedef fixed_t (logic signed [L-1:0]).
  - FIXED_MAX and FIXED_MIN constants.
  - Function saturate_to_fixed(wide signed).
  - State enum neuron_acc_state_t {ACCUM, FINISH, OUTPUT}.
- One sub-module is natural: signed_saturator, a parameterised combinational wide-to-narrow clamp. It is reused by both the accumulator bound check and the final narrowing.

Test Plan:
- Products 0x0400, 0x0200, 0xFE00 (1.0, 0.5, -0.5; last on third), bias 0x0100 -> neuron_out=0x0500 (1.25) exactly one cycle after FINISH; busy_out high from beat 1 to handshake.
- Products 0xF800, 0x0200 (-2.0, 0.5), bias 0 -> 0x0000 with RELU_EN=1; 0xFA00 (-1.5) with RELU_EN=0.
- Four beats 0x7FFF, bias 0x7FFF -> 0x7FFF. Four beats 0x8000, bias 0x8000, RELU_EN=0 -> 0x8000.
- 300 beats of 0x7FFF -> internal acc clamps at 0x7FFFFF with no wrap; neuron_out=0x7FFF.
- Backpressure: neuron_ready_in=0 for 5 cycles after valid -> neuron_out stable, product_ready_out=0, next upstream beat held. Release -> handshake, then the next vector's first beat is accepted the following cycle starting from acc=0.
- Reset mid-vector: rst_n_in low after 2 of 4 beats -> all outputs 0 immediately. A fresh single-beat vector 0x0400 with bias 0 -> 0x0400, with no residue from the aborted vector.

Source files
------------

// File: rtl/nn_fixed_point_pkg.sv
// Shared Q5.10 fixed-point definitions for the neuron datapath blocks.
package nn_fixed_point_pkg;

    localparam int FIXED_POINT_LENGTH   = 16;
    localparam int FIXED_POINT_POSITION = 10;

    typedef logic signed [FIXED_POINT_LENGTH-1:0] fixed_t;

    localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_POINT_LENGTH-1){1'b1}}};
    localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_POINT_LENGTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FINISH = 2'd1,
        OUTPUT = 2'd2
    } neuron_acc_state_t;

    function automatic fixed_t saturate_to_fixed(input logic signed [31:0] value);
        fixed_t result;
        if (value > FIXED_MAX) begin
            result = FIXED_MAX;
        end else if (value < FIXED_MIN) begin
            result = FIXED_MIN;
        end else begin
            result = value[FIXED_POINT_LENGTH-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/signed_saturator.sv
// Combinational clamp of a wide two's-complement value into a narrower signed range.
module signed_saturator #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  wide,
    output logic signed [OUT_W-1:0] narrow
);

    localparam int HI_W = IN_W - OUT_W + 1;

    logic [HI_W-1:0] hi_bits;

    // The value fits when every bit above the narrow sign bit copies it.
    assign hi_bits = wide[IN_W-1:OUT_W-1];

    always_comb begin
        if ((hi_bits == {HI_W{1'b0}}) || (hi_bits == {HI_W{1'b1}})) begin
            narrow = wide[OUT_W-1:0];
        end else if (wide[IN_W-1]) begin
            narrow = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            narrow = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums one neuron's product stream in a guarded accumulator, adds bias,
// saturates, optionally applies ReLU and offers the activation on valid/ready.
//
//   state  | meaning
//   ACCUM  | accepting product beats, accumulating with saturation
//   FINISH | one cycle: add bias, narrow, activate, register result
//   OUTPUT | activation held on neuron_out until neuron_ready_in
module neuron_accumulator #(
    parameter int FIXED_POINT_LENGTH   = nn_fixed_point_pkg::FIXED_POINT_LENGTH,
    parameter int FIXED_POINT_POSITION = nn_fixed_point_pkg::FIXED_POINT_POSITION,
    parameter int ACCUM_GUARD_BITS     = 8,
    parameter bit RELU_EN              = 1'b1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [FIXED_POINT_LENGTH-1:0] product_in,
    input  logic                          product_valid_in,
    input  logic                          product_last_in,
    output logic                          product_ready_out,
    input  logic [FIXED_POINT_LENGTH-1:0] bias_in,
    output logic [FIXED_POINT_LENGTH-1:0] neuron_out,
    output logic                          neuron_valid_out,
    input  logic                          neuron_ready_in,
    output logic                          busy_out
);

    import nn_fixed_point_pkg::*;

    localparam int L = FIXED_POINT_LENGTH;
    // Addition is scale-preserving, so the binary point never shifts anything here.
    localparam int ACC_W = L + ACCUM_GUARD_BITS + 0 * FIXED_POINT_POSITION;

    neuron_acc_state_t state;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W:0]   out_sum;
    logic [L-1:0]            bias_reg;
    logic signed [L-1:0]     out_sat;
    logic [L-1:0]            activation;
    logic                    beat;

    assign product_ready_out = (state == ACCUM);
    assign beat              = product_valid_in && product_ready_out;

    assign acc_sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-L){product_in[L-1]}}, product_in};
    assign out_sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-L){bias_reg[L-1]}}, bias_reg};

    signed_saturator #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_acc_sat (
        .wide   (acc_sum),
        .narrow (acc_next)
    );

    signed_saturator #(.IN_W(ACC_W + 1), .OUT_W(L)) u_out_sat (
        .wide   (out_sum),
        .narrow (out_sat)
    );

    assign activation = (RELU_EN && out_sat[L-1]) ? '0 : out_sat;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= ACCUM;
            acc              <= '0;
            bias_reg         <= '0;
            neuron_out       <= '0;
            neuron_valid_out <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        acc      <= acc_next;
                        busy_out <= 1'b1;
                        if (product_last_in) begin
                            bias_reg <= bias_in;
                            state    <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    neuron_out       <= activation;
                    neuron_valid_out <= 1'b1;
                    state            <= OUTPUT;
                end
                OUTPUT: begin
                    if (neuron_ready_in) begin
                        neuron_valid_out <= 1'b0;
                        acc              <= '0;
                        busy_out         <= 1'b0;
                        state            <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed and randomized checks of neuron_accumulator against an arithmetic reference model.
module tb_neuron_accumulator;

    logic        clk_in;
    logic        rst_n_in;
    logic [15:0] product_in;
    logic        product_valid_in;
    logic        product_last_in;
    logic [15:0] bias_in;
    logic        neuron_ready_in;

    logic        ready_r, ready_n;
    logic [15:0] out_r, out_n;
    logic        valid_r, valid_n;
    logic        busy_r, busy_n;

    int checks = 0;
    int errors = 0;

    int prods[$];
    int bias;

    neuron_accumulator #(.RELU_EN(1'b1)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .product_in        (product_in),
        .product_valid_in  (product_valid_in),
        .product_last_in   (product_last_in),
        .product_ready_out (ready_r),
        .bias_in           (bias_in),
        .neuron_out        (out_r),
        .neuron_valid_out  (valid_r),
        .neuron_ready_in   (neuron_ready_in),
        .busy_out          (busy_r)
    );

    neuron_accumulator #(.RELU_EN(1'b0)) dut_nr (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .product_in        (product_in),
        .product_valid_in  (product_valid_in),
        .product_last_in   (product_last_in),
        .product_ready_out (ready_n),
        .bias_in           (bias_in),
        .neuron_out        (out_n),
        .neuron_valid_out  (valid_n),
        .neuron_ready_in   (neuron_ready_in),
        .busy_out          (busy_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference: exact integer sum clamped to 24-bit range after each add,
    // then bias, clamp to 16-bit range, optional ReLU.
    function automatic logic [15:0] model(input bit relu);
        longint acc;
        longint s;
        acc = 0;
        foreach (prods[k]) begin
            acc = acc + prods[k];
            if (acc > 64'sd8388607)  acc = 64'sd8388607;
            if (acc < -64'sd8388608) acc = -64'sd8388608;
        end
        s = acc + bias;
        if (s > 64'sd32767)  s = 64'sd32767;
        if (s < -64'sd32768) s = -64'sd32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic send_beats(input string tag, input bit gaps);
        int  i;
        int  budget;
        int  v;
        bit  acc_ok;
        i = 0;
        budget = 0;
        check({tag, "_busy_idle"}, {31'd0, busy_r}, 32'd0);
        while (i < prods.size() && budget < 5000) begin
            budget++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                product_valid_in = 1'b0;
                product_last_in  = 1'($urandom_range(0, 1));
                product_in       = 16'($urandom);
                neuron_ready_in  = 1'($urandom_range(0, 1));
                @(negedge clk_in);
            end else begin
                v = prods[i];
                product_valid_in = 1'b1;
                product_in       = 16'(v);
                product_last_in  = (i == prods.size() - 1);
                bias_in          = 16'(bias);
                neuron_ready_in  = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
                acc_ok = ready_r;
                @(negedge clk_in);
                if (acc_ok) begin
                    i++;
                    if (i == 1) check({tag, "_busy_first"}, {31'd0, busy_r}, 32'd1);
                end
            end
        end
        if (i < prods.size()) check({tag, "_beat_timeout"}, i, prods.size());
    endtask

    // Called at the negedge right after the last beat was accepted.
    task automatic expect_output(input string tag, input int hold);
        logic [15:0] er;
        logic [15:0] en;
        er = model(1'b1);
        en = model(1'b0);
        neuron_ready_in = 1'b0;
        check({tag, "_finish_valid"}, {31'd0, valid_r}, 32'd0);
        check({tag, "_finish_ready"}, {31'd0, ready_r}, 32'd0);
        @(negedge clk_in);
        check({tag, "_valid"},   {30'd0, valid_r, valid_n}, 32'd3);
        check({tag, "_out_relu"}, {16'd0, out_r}, {16'd0, er});
        check({tag, "_out_norelu"}, {16'd0, out_n}, {16'd0, en});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_in);
            check({tag, "_hold"}, {out_r, out_n}, {er, en});
            check({tag, "_hold_ctl"}, {29'd0, valid_r, ready_r, busy_r}, 32'd5);
        end
        neuron_ready_in = 1'b1;
        @(negedge clk_in);
        neuron_ready_in = 1'b0;
        check({tag, "_release"}, {29'd0, valid_r, ready_r, busy_r}, 32'd2);
        check({tag, "_release_nr"}, {30'd0, valid_n, busy_n}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n_in         = 1'b0;
        product_in       = '0;
        product_valid_in = 1'b0;
        product_last_in  = 1'b0;
        bias_in          = '0;
        neuron_ready_in  = 1'b0;
        #1;
        check("reset", {out_r, 11'd0, valid_r, ready_r, busy_r, 2'd0}, 32'h0000_0008);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // 1.0 + 0.5 - 0.5 + 0.25 bias
        prods = '{s16(16'h0400), s16(16'h0200), s16(16'hFE00)};
        bias  = s16(16'h0100);
        send_beats("basic", 1'b0);
        expect_output("basic", 2);

        prods = '{s16(16'hF800), s16(16'h0200)};
        bias  = 0;
        send_beats("neg", 1'b0);
        expect_output("neg", 0);

        prods = '{s16(16'h7FFF), s16(16'h7FFF), s16(16'h7FFF), s16(16'h7FFF)};
        bias  = s16(16'h7FFF);
        send_beats("posmax", 1'b1);
        expect_output("posmax", 1);

        prods = '{s16(16'h8000), s16(16'h8000), s16(16'h8000), s16(16'h8000)};
        bias  = s16(16'h8000);
        send_beats("negmax", 1'b1);
        expect_output("negmax", 1);

        prods = {};
        for (int k = 0; k < 300; k++) prods.push_back(s16(16'h7FFF));
        bias = 0;
        send_beats("acc_sat", 1'b0);
        check("acc_sat_internal", 32'(unsigned'(dut.acc)), 32'h007F_FFFF);
        expect_output("acc_sat", 0);

        // Next vector's beat is held valid through FINISH/OUTPUT backpressure.
        prods = '{s16(16'h0C00), s16(16'h0400)};
        bias  = s16(16'hFF00);
        send_beats("bp", 1'b0);
        product_valid_in = 1'b1;
        product_in       = 16'h0400;
        product_last_in  = 1'b1;
        bias_in          = 16'h0000;
        expect_output("bp", 5);
        prods = '{s16(16'h0400)};
        bias  = 0;
        send_beats("bp_next", 1'b0);
        expect_output("bp_next", 0);

        // Abort a vector after two of four beats.
        product_valid_in = 1'b1;
        product_in       = 16'h1000;
        product_last_in  = 1'b0;
        bias_in          = 16'h0100;
        @(negedge clk_in);
        @(negedge clk_in);
        product_valid_in = 1'b0;
        check("abort_busy", {31'd0, busy_r}, 32'd1);
        rst_n_in = 1'b0;
        #1;
        check("abort_reset", {out_r, out_n, valid_r, valid_n, busy_r, busy_n, ready_r, 11'd0},
              32'h0000_0800);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        prods = '{s16(16'h0400)};
        bias  = 0;
        send_beats("post_reset", 1'b0);
        expect_output("post_reset", 0);

        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 8);
            prods = {};
            for (int k = 0; k < n; k++) prods.push_back(s16(16'($urandom)));
            bias = s16(16'($urandom));
            send_beats("rand", 1'b1);
            expect_output("rand", $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
